ir_code_display: RTL and testbench
==================================

Name: ir_code_display

Overview:
- Parametrised successor to the one-hot troubleshooting decoder for the IR receiver.
- Captures each decoded IR code on a valid strobe and shows it as hexadecimal on NUM_DIGITS active-low seven-segment displays.
- Holds the displayed code for a programmable time, then blanks the displays.
- Counts received codes, giving a debug view of receiver activity on the board.

Parameters:
- DATA_W, 8: width of data_in in bits; NUM_DIGITS*4 >= DATA_W is required (checked by elaboration assertion).
- NUM_DIGITS, 2: number of seven-segment digits driven.
- HOLD_CYCLES, 50_000_000: clk cycles a code stays visible after its last capture; 0 means hold forever.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- data_in  input  DATA_W  decoded IR code.
- data_valid  input  1  single-cycle strobe; data_in is captured in the cycle it is high.
- clear  input  1  synchronous request to blank the display and zero the captured code.
- segments  output  NUM_DIGITS*7  active-low segments. Digit i is segments[7i+6:7i], bit order g..a; digit 0 is least significant.
- shown  output  1  high while a code is being displayed.
- code_count  output  8  number of accepted codes, wraps modulo 256.

Behaviour:
- Reset is synchronous: every flop takes its reset value at a clk edge with rst high. rst overrides all other inputs.
- Reset values:
  - segments all 1 (blank)
  - shown 0
  - code_count 0
  - captured code 0
  - timer 0
  - state IDLE
- States:
  - IDLE: display blank, shown=0.
  - SHOW: captured code displayed, shown=1.
- Priority each cycle: rst > clear > data_valid > timer expiry.
- clear:
  - Sets state to IDLE, captured code to 0, timer to 0.
  - code_count is unchanged.
  - If data_valid is high in the same cycle, the code is dropped and code_count does not increment.
- data_valid (without clear), from either state:
  - Captures data_in, zero-extended to NUM_DIGITS*4 bits.
  - Loads timer with HOLD_CYCLES-1, sets state to SHOW, increments code_count.
  - A new strobe while in SHOW retriggers the hold: timer reloads and the new value replaces the old.
- Timer in SHOW:
  - Decrements by 1 each cycle.
  - When timer==0 and no data_valid: state goes to IDLE on that edge.
  - A code is visible for exactly HOLD_CYCLES cycles after its capture edge.
- HOLD_CYCLES==0: timer is never loaded or decremented; SHOW persists until clear or rst.
- Timer width is max(1, $clog2(HOLD_CYCLES+1)).
- Latency:
  - shown and code_count update on the capture edge.
  - segments are registered and update one edge later (1-cycle latency).
  - Blanking on timeout or clear also appears one edge after the state change.
- Hex font (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Digits above the data width show 0 (see optional feature).
- code_count wraps 255 -> 0 with no flag.

Optional Feature:
- Macro IR_DISP_BLANK_LEADING_EN.
- Defined: in SHOW, each most-significant digit that is 0 and has only zero digits above it is blanked. Digit 0 is always shown, so code 0x05 on 2 digits shows "_5".
- Undefined: all NUM_DIGITS digits are always shown in SHOW ("05").

Decomposition:
- Package ir_disp_pkg holds:
  - the state enum type (IDLE, SHOW)
  - localparam SEG_BLANK = 7'b1111111
  - the 16-entry hex font constant array
- Sub-module hex_to_7seg: combinational 4-bit nibble to 7-bit active-low decoder using the package font. Instantiated NUM_DIGITS times via generate.
- Timer, state register, counter and output registers live in ir_code_display.

Test Plan:
All scenarios use HOLD_CYCLES=10, DATA_W=8, NUM_DIGITS=2 unless stated.
- rst high for 2 cycles -> segments=14'h3FFF, shown=0, code_count=0; rst asserted mid-SHOW blanks everything on the next edge.
- data_valid with data_in=8'hA7 -> shown=1 on the same edge; next edge segments digit1=0001000, digit0=1111000; code_count=1.
- Capture 8'h3C, no further input -> shown stays 1 for exactly 10 cycles, then 0; segments blank one cycle after that.
- Capture 8'h11, then 8'h22 five cycles later -> display changes to "22", hold restarts for 10 cycles from the second capture, code_count=2.
- clear and data_valid (8'h55) in the same cycle -> IDLE, code dropped, code_count unchanged, display blank.
- 256 strobes -> code_count wraps to 0.
- HOLD_CYCLES=0 -> display persists for 1000 cycles until clear.
- With IR_DISP_BLANK_LEADING_EN, data 8'h05 -> digit1 blank, digit0=0010010.

Source files
------------

// File: rtl/ir_disp_pkg.sv
// Shared types and constants for the IR code display.
// Holds the state encoding and the active-low hex font.
package ir_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segments, bit order g..a, indexed by nibble value.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int timer_width(input int hold);
        int w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ir_code_display_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
// Uses the shared hex font table.
module hex_to_7seg
    import ir_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/ir_code_display.sv
// Captures decoded IR codes and shows them in hex for a hold time.
// Macro IR_DISP_BLANK_LEADING_EN blanks leading zero digits.
module ir_code_display
    import ir_disp_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_DIGITS  = 2,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    data_valid,
    input  logic                    clear,
    output logic [NUM_DIGITS*7-1:0] segments,
    output logic                    shown,
    output logic [7:0]              code_count
);

    localparam int CODE_W  = NUM_DIGITS * 4;
    localparam int SEG_W   = NUM_DIGITS * 7;
    localparam int TW      = timer_width(HOLD_CYCLES);
    localparam int HOLD_M1 = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_M1);
    localparam bit HOLD_EN = (HOLD_CYCLES != 0);

    if (CODE_W < DATA_W) begin : g_bad_width
        $error("ir_code_display: NUM_DIGITS*4 must be >= DATA_W");
    end

    disp_state_e       state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        count_q, count_d;
    logic [SEG_W-1:0]  seg_q, seg_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        timer_d = timer_q;
        count_d = count_q;
        if (clear) begin
            state_d = IDLE;
            code_d  = '0;
            timer_d = '0;
        end else if (data_valid) begin
            state_d = SHOW;
            code_d  = CODE_W'(data_in);
            count_d = count_q + 8'd1;
            if (HOLD_EN) begin
                timer_d = HOLD_LOAD;
            end
        end else if (state_q == SHOW && HOLD_EN) begin
            if (timer_q == '0) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    logic [6:0] dec [NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        hex_to_7seg u_dec (
            .nibble (code_q[4*i +: 4]),
            .seg    (dec[i])
        );
    end

    logic [NUM_DIGITS-1:0] lead_blank;

`ifdef IR_DISP_BLANK_LEADING_EN
    logic above_zero;

    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        above_zero = 1'b1;
        lead_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            above_zero    = above_zero && (code_q[4*i +: 4] == 4'h0);
            lead_blank[i] = above_zero;
        end
    end
`else
    assign lead_blank = '0;
`endif

    always_comb begin
        seg_d = '1;
        if (state_q == SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_d[7*i +: 7] = lead_blank[i] ? SEG_BLANK : dec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            timer_q <= '0;
            count_q <= '0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            timer_q <= timer_d;
            count_q <= count_d;
            seg_q   <= seg_d;
        end
    end

    assign segments   = seg_q;
    assign shown      = (state_q == SHOW);
    assign code_count = count_q;

endmodule

// File: tb/tb_ir_code_display.sv
// Directed self-checking bench for ir_code_display.
// Runs a HOLD_CYCLES=10 instance and a hold-forever instance side by side.
module tb_ir_code_display;

    localparam logic [6:0] F0 = 7'b1000000;
    localparam logic [6:0] F2 = 7'b0100100;
    localparam logic [6:0] F3 = 7'b0110000;
    localparam logic [6:0] F5 = 7'b0010010;
    localparam logic [6:0] F7 = 7'b1111000;
    localparam logic [6:0] F9 = 7'b0010000;
    localparam logic [6:0] FA = 7'b0001000;
    localparam logic [6:0] FC = 7'b1000110;
    localparam logic [6:0] FE = 7'b0000110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [13:0] BLANK2 = 14'h3FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        clear;
    logic [13:0] segments;
    logic        shown;
    logic [7:0]  code_count;
    logic [13:0] segments0;
    logic        shown0;
    logic [7:0]  code_count0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ir_code_display #(
        .DATA_W      (8),
        .NUM_DIGITS  (2),
        .HOLD_CYCLES (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .segments   (segments),
        .shown      (shown),
        .code_count (code_count)
    );

    ir_code_display #(
        .DATA_W      (8),
        .NUM_DIGITS  (2),
        .HOLD_CYCLES (0)
    ) dut_hold0 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .segments   (segments0),
        .shown      (shown0),
        .code_count (code_count0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        data_in    = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    logic stayed;

    initial begin
        rst        = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        clear      = 1'b0;
        tick();
        tick();
        check("rst_seg", 32'(segments), 32'(BLANK2));
        check("rst_shown", 32'(shown), 32'd0);
        check("rst_count", 32'(code_count), 32'd0);
        rst = 1'b0;
        tick();

        strobe(8'hA7);
        check("a7_shown", 32'(shown), 32'd1);
        check("a7_count", 32'(code_count), 32'd1);
        check("a7_seg_lat", 32'(segments), 32'(BLANK2));
        tick();
        check("a7_seg", 32'(segments), 32'({FA, F7}));

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_shown", 32'(shown), 32'd0);
        check("clr_count", 32'(code_count), 32'd1);
        tick();
        check("clr_seg", 32'(segments), 32'(BLANK2));

        // Capture edge is E0; shown must hold through E9 and drop at E10.
        strobe(8'h3C);
        stayed = shown;
        for (int k = 1; k < 10; k++) begin
            tick();
            stayed = stayed & shown;
        end
        check("3c_hold", 32'(stayed), 32'd1);
        check("3c_seg", 32'(segments), 32'({F3, FC}));
        tick();
        check("3c_drop", 32'(shown), 32'd0);
        check("3c_seg_lat", 32'(segments), 32'({F3, FC}));
        tick();
        check("3c_blank", 32'(segments), 32'(BLANK2));
        check("3c_count", 32'(code_count), 32'd2);

        strobe(8'h11);
        for (int k = 1; k < 5; k++) tick();
        strobe(8'h22);
        check("22_count", 32'(code_count), 32'd4);
        stayed = shown;
        tick();
        check("22_seg", 32'(segments), 32'({F2, F2}));
        stayed = stayed & shown;
        for (int k = 7; k <= 14; k++) begin
            tick();
            stayed = stayed & shown;
        end
        check("22_retrig", 32'(stayed), 32'd1);
        tick();
        check("22_drop", 32'(shown), 32'd0);

        strobe(8'h66);
        clear      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h55;
        tick();
        clear      = 1'b0;
        data_valid = 1'b0;
        check("cv_shown", 32'(shown), 32'd0);
        check("cv_count", 32'(code_count), 32'd5);
        tick();
        check("cv_seg", 32'(segments), 32'(BLANK2));

        strobe(8'h77);
        tick();
        check("mid_seg", 32'(segments), 32'({F7, F7}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_seg", 32'(segments), 32'(BLANK2));
        check("mid_rst_shown", 32'(shown), 32'd0);
        check("mid_rst_count", 32'(code_count), 32'd0);

        data_valid = 1'b1;
        for (int k = 0; k < 255; k++) begin
            data_in = 8'(k);
            tick();
        end
        check("wrap_255", 32'(code_count), 32'd255);
        tick();
        data_valid = 1'b0;
        check("wrap_0", 32'(code_count), 32'd0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        strobe(8'h05);
        tick();
`ifdef IR_DISP_BLANK_LEADING_EN
        check("lead_05", 32'(segments), 32'({BL, F5}));
`else
        check("lead_05", 32'(segments), 32'({F0, F5}));
`endif

        rst = 1'b1;
        tick();
        rst = 1'b0;
        strobe(8'h9E);
        stayed = shown0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            stayed = stayed & shown0;
        end
        check("h0_hold", 32'(stayed), 32'd1);
        check("h0_seg", 32'(segments0), 32'({F9, FE}));
        check("h0_count", 32'(code_count0), 32'd1);
        check("h10_gone", 32'(shown), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("h0_clr", 32'(shown0), 32'd0);
        tick();
        check("h0_blank", 32'(segments0), 32'(BLANK2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
